// File: rtl/four_vote_ballot_collector_if.sv
// Ballot collector bus: session control and vote pulses toward the
// collector, frozen ballot and status flags back toward the tally side.
interface four_vote_ballot_collector_if;
    logic       open_i;
    logic       close_i;
    logic [3:0] vote_yes;
    logic [3:0] vote_no;
    logic [3:0] ballot;
    logic [3:0] voted;
    logic       ballot_valid;
    logic       busy;
    logic       timed_out;

    // Push-button / session controller side
    modport master (
        output open_i, close_i, vote_yes, vote_no,
        input  ballot, voted, ballot_valid, busy, timed_out
    );

    // Collector side
    modport slave (
        input  open_i, close_i, vote_yes, vote_no,
        output ballot, voted, ballot_valid, busy, timed_out
    );
endinterface

// File: rtl/four_vote_ballot_collector.sv
// Four-voter ballot collector: opens a session, records at most one
// yes/no vote per voter, closes on full ballot, early close or timeout,
// and then holds a frozen ballot for the combinational tally.
module four_vote_ballot_collector #(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input logic                          clk,
    input logic                          rst,
    four_vote_ballot_collector_if.slave  bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OPEN   = 2'd1,
        CLOSED = 2'd2
    } state_t;

    state_t        state_reg, state_next;
    logic [3:0]    ballot_reg, ballot_next;
    logic [3:0]    voted_reg, voted_next;
    logic          timed_out_reg, timed_out_next;
    logic          busy_reg, busy_next;
    logic          valid_reg, valid_next;
    logic [TW-1:0] timer_reg, timer_next;
    logic [3:0]    accept;

    // A vote counts only when exactly one of yes/no is pulsed and the
    // voter has not voted yet; a simultaneous yes+no leaves the voter free.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_voter
            assign accept[gi] = (bus.vote_yes[gi] ^ bus.vote_no[gi]) & ~voted_reg[gi];
        end
    endgenerate

    // State and output registers; reset discards any partial ballot at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            ballot_reg    <= 4'h0;
            voted_reg     <= 4'h0;
            timed_out_reg <= 1'b0;
            busy_reg      <= 1'b0;
            valid_reg     <= 1'b0;
            timer_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            ballot_reg    <= ballot_next;
            voted_reg     <= voted_next;
            timed_out_reg <= timed_out_next;
            busy_reg      <= busy_next;
            valid_reg     <= valid_next;
            timer_reg     <= timer_next;
        end
    end

    // Next-state and next-output logic; everything holds unless changed.
    always_comb begin
        state_next     = state_reg;
        ballot_next    = ballot_reg;
        voted_next     = voted_reg;
        timed_out_next = timed_out_reg;
        timer_next     = timer_reg;

        case (state_reg)
            IDLE: begin
                if (bus.open_i) begin
                    state_next     = OPEN;
                    ballot_next    = 4'h0;
                    voted_next     = 4'h0;
                    timed_out_next = 1'b0;
                    timer_next     = '0;
                end
            end
            OPEN: begin
                // Votes of this cycle are applied before any exit decision,
                // so a vote landing in the closing cycle is always kept.
                ballot_next = (ballot_reg & ~accept) | (bus.vote_yes & accept);
                voted_next  = voted_reg | accept;
                if (voted_next == 4'hF) begin
                    state_next     = CLOSED;
                    timed_out_next = 1'b0;
                end else if (bus.close_i) begin
                    state_next     = CLOSED;
                    timed_out_next = 1'b0;
                end else if (timer_reg == TIMER_LAST) begin
                    state_next     = CLOSED;
                    timed_out_next = 1'b1;
                end else begin
                    timer_next = timer_reg + TW'(1);
                end
            end
            CLOSED: begin
                if (bus.open_i) begin
                    state_next     = OPEN;
                    ballot_next    = 4'h0;
                    voted_next     = 4'h0;
                    timed_out_next = 1'b0;
                    timer_next     = '0;
                end
            end
            default: begin
                state_next     = IDLE;
                ballot_next    = 4'h0;
                voted_next     = 4'h0;
                timed_out_next = 1'b0;
                timer_next     = '0;
            end
        endcase

        busy_next  = (state_next == OPEN);
        valid_next = (state_next == CLOSED);
    end

    assign bus.ballot       = ballot_reg;
    assign bus.voted        = voted_reg;
    assign bus.ballot_valid = valid_reg;
    assign bus.busy         = busy_reg;
    assign bus.timed_out    = timed_out_reg;
endmodule

// File: tb/tb_four_vote_ballot_collector.sv
// Self-checking bench for four_vote_ballot_collector (TIMEOUT_CYCLES=8):
// a table of directed single-cycle vectors plus hand-written sequences
// for timeout and asynchronous reset.
module tb_four_vote_ballot_collector;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    four_vote_ballot_collector_if bus ();

    four_vote_ballot_collector #(.TIMEOUT_CYCLES(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       open;
        logic       close;
        logic [3:0] yes;
        logic [3:0] no;
        logic [3:0] b;
        logic [3:0] v;
        logic       valid;
        logic       busy;
        logic       to;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] b, input logic [3:0] v,
                           input logic valid, input logic busy, input logic to);
        chk({tag, "_ballot"}, bus.ballot, b);
        chk({tag, "_voted"}, bus.voted, v);
        chk({tag, "_valid"}, {3'b0, bus.ballot_valid}, {3'b0, valid});
        chk({tag, "_busy"}, {3'b0, bus.busy}, {3'b0, busy});
        chk({tag, "_timed_out"}, {3'b0, bus.timed_out}, {3'b0, to});
    endtask

    // Drive one cycle of inputs, let one rising edge pass, sample 1 time unit later.
    task automatic step(input logic op, input logic cl, input logic [3:0] y, input logic [3:0] n);
        bus.open_i   = op;
        bus.close_i  = cl;
        bus.vote_yes = y;
        bus.vote_no  = n;
        @(posedge clk);
        #1;
        bus.open_i   = 1'b0;
        bus.close_i  = 1'b0;
        bus.vote_yes = 4'h0;
        bus.vote_no  = 4'h0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        bus.open_i = 1'b0; bus.close_i = 1'b0;
        bus.vote_yes = 4'h0; bus.vote_no = 4'h0;

        //             open close yes    no     ballot voted  val busy to
        vecs[0]  = '{1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 4'h1, 4'h0, 4'h1, 4'h1, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 4'h0, 4'h2, 4'h1, 4'h3, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 4'h4, 4'h0, 4'h5, 4'h7, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 4'h0, 4'h8, 4'h5, 4'hF, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 4'hF, 4'h0, 4'h5, 4'hF, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 4'hF, 4'h0, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 4'h2, 4'h0, 4'h2, 4'h2, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 4'h0, 4'h2, 4'h2, 4'h2, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 4'h0, 4'h0, 4'h2, 4'h2, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 4'h8, 4'h8, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 4'h8, 4'h0, 4'h8, 4'h8, 1'b0, 1'b1, 1'b0};
        vecs[15] = '{1'b1, 1'b0, 4'h0, 4'h0, 4'h8, 4'h8, 1'b0, 1'b1, 1'b0};
        vecs[16] = '{1'b0, 1'b1, 4'h0, 4'h0, 4'h8, 4'h8, 1'b1, 1'b0, 1'b0};
        vecs[17] = '{1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0};
        vecs[18] = '{1'b0, 1'b1, 4'h1, 4'h0, 4'h1, 4'h1, 1'b1, 1'b0, 1'b0};

        // Reset state, then votes and close in IDLE must be ignored
        rst = 1'b1;
        #12;
        chk_all("reset", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        step(1'b0, 1'b1, 4'h5, 4'h2);
        chk_all("idle_ignore", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        $display("idle: votes/close ignored, busy=%0b valid=%0b", bus.busy, bus.ballot_valid);

        // Table-driven vectors
        for (int i = 0; i < NV; i++) begin
            step(vecs[i].open, vecs[i].close, vecs[i].yes, vecs[i].no);
            chk_all($sformatf("vec%0d", i), vecs[i].b, vecs[i].v,
                    vecs[i].valid, vecs[i].busy, vecs[i].to);
            $display("vec%0d: open=%0b close=%0b yes=%h no=%h -> ballot=%h voted=%h valid=%0b busy=%0b to=%0b",
                     i, vecs[i].open, vecs[i].close, vecs[i].yes, vecs[i].no,
                     bus.ballot, bus.voted, bus.ballot_valid, bus.busy, bus.timed_out);
        end

        // Timeout: open, one vote, then silence; busy for 8 edges
        step(1'b1, 1'b0, 4'h0, 4'h0);
        chk_all("to_open", 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 4'h1, 4'h0);
        chk_all("to_edge1", 4'h1, 4'h1, 1'b0, 1'b1, 1'b0);
        for (int k = 2; k < 8; k++) begin
            step(1'b0, 1'b0, 4'h0, 4'h0);
            chk_all($sformatf("to_edge%0d", k), 4'h1, 4'h1, 1'b0, 1'b1, 1'b0);
        end
        step(1'b0, 1'b0, 4'h0, 4'h0);
        chk_all("to_expire", 4'h1, 4'h1, 1'b1, 1'b0, 1'b1);
        $display("timeout: ballot=%h timed_out=%0b", bus.ballot, bus.timed_out);

        // Fourth vote lands exactly when timer is at its last value
        step(1'b1, 1'b0, 4'h0, 4'h0);
        chk_all("last_open", 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 4'h1, 4'h0);
        step(1'b0, 1'b0, 4'h2, 4'h0);
        step(1'b0, 1'b0, 4'h4, 4'h0);
        for (int k = 4; k < 8; k++) step(1'b0, 1'b0, 4'h0, 4'h0);
        chk_all("last_pre", 4'h7, 4'h7, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 4'h0, 4'h8);
        chk_all("last_vote", 4'h7, 4'hF, 1'b1, 1'b0, 1'b0);
        $display("vote at timer=7: ballot=%h timed_out=%0b", bus.ballot, bus.timed_out);

        // Asynchronous reset between edges mid-session
        step(1'b1, 1'b0, 4'h0, 4'h0);
        step(1'b0, 1'b0, 4'h1, 4'h0);
        step(1'b0, 1'b0, 4'h0, 4'h2);
        chk_all("pre_rst", 4'h1, 4'h3, 1'b0, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk_all("async_rst", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        step(1'b0, 1'b0, 4'hF, 4'h0);
        chk_all("post_rst_idle", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 4'h0, 4'h0);
        chk_all("post_rst_open", 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
        $display("async reset: cleared, reopened busy=%0b", bus.busy);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // busy and ballot_valid must never be high together
    always @(negedge clk) begin
        if (!rst) begin
            n_checks++;
            if (bus.busy && bus.ballot_valid) begin
                n_fail++;
                $display("FAIL busy_valid_exclusive: got busy=%0b valid=%0b required not both 1",
                         bus.busy, bus.ballot_valid);
            end
        end
    end
endmodule

// File: doc/four_vote_ballot_collector.md
# four_vote_ballot_collector

Sequential front end for the four-voter tally: it opens a voting session, captures at most one yes/no vote per voter, and closes the session. On close it presents a frozen 4-bit ballot (1 = yes) with a valid flag, ready to drive the 4-bit voter input of the combinational vote machine. It stays between the voter push-buttons (already synchronised, single-cycle pulses) and the tally logic.

## Interface
- TIMEOUT_CYCLES, 1000, maximum length of the OPEN state in clock cycles (>= 2)
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- open_i  in  1  pulse: start a new session
- close_i  in  1  pulse: end the session early
- vote_yes  in  4  per-voter yes pulse, bit i = voter i
- vote_no  in  4  per-voter no pulse, bit i = voter i
- ballot  out  4  captured votes, 1 = yes; drives the vote machine input I[3:0]
- voted  out  4  bit i set once voter i has cast a vote this session
- ballot_valid  out  1  high while in CLOSED; ballot is frozen
- busy  out  1  high while in OPEN
- timed_out  out  1  high in CLOSED only when the session ended by timeout

## Operation
- One clock (clk); reset is asynchronous and active-high (rst). All outputs are registered.
- On rst: state IDLE, ballot=0, voted=0, ballot_valid=0, busy=0, timed_out=0, timer=0. Applies immediately, including mid-session. Any partial ballot is discarded.
- States: IDLE, OPEN, CLOSED (2-bit encoding).
- IDLE: open_i -> OPEN. close_i, vote_yes and vote_no are ignored.
- Entering OPEN (from IDLE or CLOSED): ballot=0, voted=0, timed_out=0, timer=0. Votes present in the entry cycle are ignored.
- OPEN, per voter i with voted[i]=0:
  - yes only -> ballot[i]=1, voted[i]=1.
  - no only -> ballot[i]=0, voted[i]=1.
  - yes and no in the same cycle -> ignored; the voter may vote again later.
- OPEN, voter with voted[i]=1: further pulses are ignored, so a vote cannot be changed.
- OPEN exit conditions, evaluated on each edge after that cycle's votes are applied. Priority is highest first:
  - (voted | accepted votes this cycle) == 4'hF -> CLOSED, timed_out=0.
  - close_i -> CLOSED, timed_out=0.
  - timer == TIMEOUT_CYCLES-1 -> CLOSED, timed_out=1.
  - otherwise timer increments.
- open_i is ignored while in OPEN.
- Votes arriving in the closing cycle are always accepted.
- CLOSED:
  - ballot, voted and timed_out are held.
  - Voters that did not vote read as 0 (no).
  - open_i -> OPEN, which starts a new session.
  - close_i and votes are ignored.
- Timer width is $clog2(TIMEOUT_CYCLES). The timer is not used outside OPEN.

## Timing
- Vote pulse sampled at edge N: ballot/voted update at edge N. busy and ballot_valid change at the same edge as the state.
- open_i sampled at edge N: busy=1 and ballot=0 after edge N.
- The last missing vote at edge N gives ballot_valid=1 and busy=0 after edge N. Latency is 0 extra cycles.
- With no votes and no close, OPEN lasts exactly TIMEOUT_CYCLES cycles: busy is high for TIMEOUT_CYCLES edges, then ballot_valid=1 and timed_out=1.
- ballot is stable for the whole CLOSED state. Downstream tally output is valid combinationally whenever ballot_valid=1.
- busy and ballot_valid are never high together. Both are low only in IDLE.

## Test plan
- Reset then open_i; voters 0,2 yes and 1,3 no in separate cycles -> after the 4th vote ballot=4'b0101, voted=4'hF, ballot_valid=1, timed_out=0, busy=0.
- Voter 1 yes, then voter 1 no, then close_i -> ballot=4'b0010, voted=4'b0010, ballot_valid=1 the edge after close_i.
- Voter 3 pulses yes and no together, then yes alone, then close_i -> first pulse ignored (voted=0), final ballot=4'b1000.
- TIMEOUT_CYCLES=8, open_i, voter 0 yes, no close -> busy high 8 cycles, then ballot=4'b0001, timed_out=1. Repeat with the 4th vote landing exactly at timer=7 -> timed_out=0.
- From CLOSED with ballot=4'hF, open_i -> ballot=0, voted=0, busy=1 next edge; a yes pulse in the open_i cycle is not recorded.
- Assert rst asynchronously (between edges) mid-session with voted=4'b0011 -> all outputs 0 immediately, state IDLE. Votes after release are ignored until open_i.
